// File: rtl/instr_encoder.sv
// Field-level MIPS instruction assembler: encodes a request into a 32-bit word, assigns it a
// sequential PC, resolves absolute branch/jump targets and streams it through a valid/ready register.
module instr_encoder #(
    parameter logic [31:0] BASE_PC = 32'hBFC0_0000,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [1:0]       OP_CLASS,
    input  logic [5:0]       OP_CODE,
    input  logic [4:0]       RS,
    input  logic [4:0]       RT,
    input  logic [4:0]       RD,
    input  logic [4:0]       SHAMT,
    input  logic [5:0]       FUNCT,
    input  logic [15:0]      IMM,
    input  logic [31:0]      ADDR,
    input  logic             ABS,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [31:0]      OUT_INSTR,
    output logic [31:0]      OUT_PC,
    output logic             OUT_ILL,
    output logic [CNT_W-1:0] EMIT_CNT,
    output logic [CNT_W-1:0] ILL_CNT
);

    function automatic logic special_legal(input logic [5:0] f);
        case (f)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0C, 6'h0D,
            6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B,
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic primary_legal(input logic [5:0] op);
        case (op)
            6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
            6'h0D, 6'h0E, 6'h0F, 6'h14, 6'h15, 6'h16, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
            6'h25, 6'h26, 6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E, 6'h30, 6'h31, 6'h38,
            6'h39: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic primary_branch(input logic [5:0] op);
        case (op)
            6'h04, 6'h05, 6'h06, 6'h07, 6'h14, 6'h15, 6'h16: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic regimm_legal(input logic [4:0] rt);
        case (rt)
            5'h00, 5'h01, 5'h10, 5'h11: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic cop1_fmt_legal(input logic [4:0] fmt);
        case (fmt)
            5'h00, 5'h02, 5'h04, 5'h06, 5'h08, 5'h10, 5'h11: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_instr_q, out_instr_d;
    logic [31:0]      out_pc_q, out_pc_d;
    logic             out_ill_q, out_ill_d;
    logic [31:0]      next_pc_q, next_pc_d;
    logic [CNT_W-1:0] emit_cnt_q, emit_cnt_d;
    logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;

    logic        in_ready, accept, out_hs;
    logic [31:0] pc4, br_d;
    logic        br_ok, jmp_ok;
    logic [15:0] br_off;
    logic [25:0] jmp_tgt;
    logic        enc_legal, enc_is_br, enc_is_jmp, enc_ill;
    logic [31:0] enc_word;
    logic        unused_br_lsbs;

    // Branch offsets are relative to the delay-slot address of the word being assigned now.
    assign pc4     = next_pc_q + 32'd4;
    assign br_d    = ADDR - pc4;
    assign br_ok   = (ADDR[1:0] == 2'b00) && (br_d[31:17] == {15{br_d[17]}});
    assign br_off  = ABS ? br_d[17:2] : IMM;
    assign jmp_ok  = (ADDR[1:0] == 2'b00) && (ADDR[31:28] == pc4[31:28]);
    assign jmp_tgt = ABS ? ADDR[27:2] : {RS, RT, IMM};
    assign unused_br_lsbs = ^br_d[1:0];

    always_comb begin
        enc_legal  = 1'b0;
        enc_is_br  = 1'b0;
        enc_is_jmp = 1'b0;
        enc_word   = '0;
        unique case (OP_CLASS)
            2'd0: begin
                enc_legal = special_legal(OP_CODE);
                enc_word  = {6'b000000, RS, RT, RD, SHAMT, OP_CODE};
            end
            2'd1: begin
                enc_legal = !OP_CODE[5] && regimm_legal(OP_CODE[4:0]);
                enc_is_br = 1'b1;
                enc_word  = {6'b000001, RS, OP_CODE[4:0], br_off};
            end
            2'd2: begin
                enc_legal = primary_legal(OP_CODE);
                if (OP_CODE == 6'h02 || OP_CODE == 6'h03) begin
                    enc_is_jmp = 1'b1;
                    enc_word   = {OP_CODE, jmp_tgt};
                end else begin
                    enc_is_br = primary_branch(OP_CODE);
                    enc_word  = {OP_CODE, RS, RT, enc_is_br ? br_off : IMM};
                end
            end
            2'd3: begin
                enc_legal = !OP_CODE[5] && cop1_fmt_legal(OP_CODE[4:0]);
                if (OP_CODE[4:0] == 5'h08) begin
                    enc_is_br = 1'b1;
                    enc_word  = {6'b010001, OP_CODE[4:0], RT, br_off};
                end else if (OP_CODE[4:0] == 5'h10 || OP_CODE[4:0] == 5'h11) begin
                    enc_word = {6'b010001, OP_CODE[4:0], RT, RD, SHAMT, FUNCT};
                end else begin
                    enc_word = {6'b010001, OP_CODE[4:0], RT, RD, SHAMT, 6'b000000};
                end
            end
            default: ;
        endcase
        enc_ill = !enc_legal || (enc_is_br && ABS && !br_ok) || (enc_is_jmp && ABS && !jmp_ok);
        if (enc_ill) begin
            enc_word = '0;
        end
    end

    assign in_ready = !out_valid_q || OUT_READY;
    assign accept   = IN_VALID && in_ready;
    assign out_hs   = out_valid_q && OUT_READY;

    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        out_ill_d   = out_ill_q;
        next_pc_d   = next_pc_q;
        emit_cnt_d  = emit_cnt_q;
        ill_cnt_d   = ill_cnt_q;
        // A new accept overwrites the register in the same cycle the old word drains.
        if (accept) begin
            out_valid_d = 1'b1;
            out_instr_d = enc_word;
            out_pc_d    = next_pc_q;
            out_ill_d   = enc_ill;
            next_pc_d   = pc4;
        end else if (out_hs) begin
            out_valid_d = 1'b0;
        end
        if (out_hs && emit_cnt_q != '1) begin
            emit_cnt_d = emit_cnt_q + CNT_W'(1);
        end
        if (out_hs && out_ill_q && ill_cnt_q != '1) begin
            ill_cnt_d = ill_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            out_ill_q   <= 1'b0;
            next_pc_q   <= BASE_PC;
            emit_cnt_q  <= '0;
            ill_cnt_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            out_ill_q   <= out_ill_d;
            next_pc_q   <= next_pc_d;
            emit_cnt_q  <= emit_cnt_d;
            ill_cnt_q   <= ill_cnt_d;
        end
    end

    assign IN_READY  = in_ready;
    assign OUT_VALID = out_valid_q;
    assign OUT_INSTR = out_instr_q;
    assign OUT_PC    = out_pc_q;
    assign OUT_ILL   = out_ill_q;
    assign EMIT_CNT  = emit_cnt_q;
    assign ILL_CNT   = ill_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: table of encodings streamed through a scoreboard, plus hand-written
// stall and reset-while-pending sequences. Narrow counters make saturation reachable.
module tb_instr_encoder;

    localparam logic [31:0] BASE  = 32'hBFC0_0000;
    localparam int unsigned CW    = 4;
    localparam int unsigned CMAX  = (1 << CW) - 1;
    localparam int          NVEC  = 22;

    typedef struct {
        logic [1:0]  cls;
        logic [5:0]  code;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [31:0] addr;
        logic        abs;
        logic [31:0] instr;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

    logic          CLK, RESET_N, IN_VALID, IN_READY, ABS, OUT_VALID, OUT_READY, OUT_ILL;
    logic [1:0]    OP_CLASS;
    logic [5:0]    OP_CODE, FUNCT;
    logic [4:0]    RS, RT, RD, SHAMT;
    logic [15:0]   IMM;
    logic [31:0]   ADDR, OUT_INSTR, OUT_PC;
    logic [CW-1:0] EMIT_CNT, ILL_CNT;

    instr_encoder #(.BASE_PC(BASE), .CNT_W(CW)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .OP_CLASS(OP_CLASS), .OP_CODE(OP_CODE), .RS(RS), .RT(RT), .RD(RD), .SHAMT(SHAMT),
        .FUNCT(FUNCT), .IMM(IMM), .ADDR(ADDR), .ABS(ABS), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .OUT_INSTR(OUT_INSTR), .OUT_PC(OUT_PC), .OUT_ILL(OUT_ILL),
        .EMIT_CNT(EMIT_CNT), .ILL_CNT(ILL_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          stalls   = 0;
    int          m_emit   = 0;
    int          m_ill    = 0;
    logic [31:0] exp_pc   = BASE;
    exp_t        sb[$];
    vec_t        tbl[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int unsigned cls, code, rs, rt, rd, sh, fn, imm,
                                input logic [31:0] addr, input int unsigned abs,
                                input logic [31:0] instr, input int unsigned ill);
        vec_t v;
        v.cls = 2'(cls);  v.code = 6'(code); v.rs = 5'(rs); v.rt = 5'(rt); v.rd = 5'(rd);
        v.sh = 5'(sh);    v.fn = 6'(fn);     v.imm = 16'(imm); v.addr = addr;
        v.abs = 1'(abs);  v.instr = instr;   v.ill = 1'(ill);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        OP_CLASS = v.cls; OP_CODE = v.code; RS = v.rs; RT = v.rt; RD = v.rd; SHAMT = v.sh;
        FUNCT = v.fn; IMM = v.imm; ADDR = v.addr; ABS = v.abs;
        IN_VALID = 1'b1;
    endtask

    // Drive one request, push its expectation when the handshake is seen, drop IN_VALID after.
    task automatic send(input vec_t v);
        exp_t e;
        bit   done = 0;
        drive(v);
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge CLK);
            if (IN_READY) begin
                e.instr = v.instr; e.pc = exp_pc; e.ill = v.ill;
                sb.push_back(e);
                exp_pc = exp_pc + 32'd4;
                done = 1;
            end else begin
                stalls++;
            end
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: got IN_READY=0 for 50 cycles, expected 1");
        end
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge CLK);
            if (sb.size() == 0 && !OUT_VALID) ok = 1;
        end
        check("drain_done", 32'(ok), 32'd1);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (!RESET_N) begin
            m_emit = 0;
            m_ill  = 0;
        end else if (OUT_VALID && OUT_READY) begin
            if (sb.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_output: got word 0x%08h, expected none", OUT_INSTR);
            end else begin
                e = sb.pop_front();
                check("out_instr", OUT_INSTR, e.instr);
                check("out_pc", OUT_PC, e.pc);
                check("out_ill", 32'(OUT_ILL), 32'(e.ill));
                if (m_emit < CMAX) m_emit++;
                if (e.ill && m_ill < CMAX) m_ill++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t va, vb, vc;
        tbl[0]  = mk(0, 'h21, 1, 2, 3, 0, 0, 0, 32'h0, 0, 32'h00221821, 0);
        tbl[1]  = mk(2, 'h09, 0, 8, 0, 0, 0, 'h1234, 32'h0, 0, 32'h24081234, 0);
        tbl[2]  = mk(2, 'h04, 1, 2, 0, 0, 0, 0, 32'hBFC00000, 1, 32'h1022FFFD, 0);
        tbl[3]  = mk(2, 'h03, 0, 0, 0, 0, 0, 0, 32'hBFC00100, 1, 32'h0FF00040, 0);
        tbl[4]  = mk(0, 'h01, 1, 2, 3, 0, 0, 0, 32'h0, 0, 32'h0, 1);
        tbl[5]  = mk(2, 'h04, 1, 2, 0, 0, 0, 0, 32'hBFC40018, 1, 32'h0, 1);
        tbl[6]  = mk(2, 'h04, 1, 2, 0, 0, 0, 0, 32'hBFC20018, 1, 32'h10227FFF, 0);
        tbl[7]  = mk(2, 'h04, 1, 2, 0, 0, 0, 0, 32'hBFBE0020, 1, 32'h10228000, 0);
        tbl[8]  = mk(2, 'h04, 1, 2, 0, 0, 0, 0, 32'hBFC00022, 1, 32'h0, 1);
        tbl[9]  = mk(0, 'h00, 0, 9, 10, 4, 0, 0, 32'h0, 0, 32'h00095100, 0);
        tbl[10] = mk(1, 'h01, 3, 0, 0, 0, 0, 'h0010, 32'h0, 0, 32'h04610010, 0);
        tbl[11] = mk(1, 'h02, 3, 0, 0, 0, 0, 'h0010, 32'h0, 0, 32'h0, 1);
        tbl[12] = mk(1, 'h21, 3, 0, 0, 0, 0, 'h0010, 32'h0, 0, 32'h0, 1);
        tbl[13] = mk(3, 'h10, 0, 2, 4, 6, 'h02, 0, 32'h0, 0, 32'h46022182, 0);
        tbl[14] = mk(3, 'h00, 0, 5, 7, 3, 'h3F, 0, 32'h0, 0, 32'h440538C0, 0);
        tbl[15] = mk(3, 'h08, 0, 1, 0, 0, 0, 'h0003, 32'h0, 0, 32'h45010003, 0);
        tbl[16] = mk(3, 'h03, 0, 1, 2, 3, 0, 0, 32'h0, 0, 32'h0, 1);
        tbl[17] = mk(2, 'h10, 1, 2, 0, 0, 0, 'h0001, 32'h0, 0, 32'h0, 1);
        tbl[18] = mk(2, 'h02, 1, 2, 0, 0, 0, 'h0300, 32'h0, 0, 32'h08220300, 0);
        tbl[19] = mk(2, 'h02, 0, 0, 0, 0, 0, 0, 32'hC0000000, 1, 32'h0, 1);
        tbl[20] = mk(2, 'h23, 29, 31, 0, 0, 0, 'hFFF0, 32'h12345677, 1, 32'h8FBFFFF0, 0);
        tbl[21] = mk(1, 'h10, 4, 0, 0, 0, 0, 0, 32'hBFC00158, 1, 32'h04900040, 0);
        va = tbl[0];
        vb = tbl[1];
        vc = mk(2, 'h0D, 2, 3, 0, 0, 0, 'h00FF, 32'h0, 0, 32'h344300FF, 0);

        RESET_N = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
        OP_CLASS = '0; OP_CODE = '0; RS = '0; RT = '0; RD = '0; SHAMT = '0;
        FUNCT = '0; IMM = '0; ADDR = '0; ABS = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_out_valid", 32'(OUT_VALID), 32'd0);
        check("rst_out_instr", OUT_INSTR, 32'd0);
        check("rst_out_pc", OUT_PC, 32'd0);
        check("rst_out_ill", 32'(OUT_ILL), 32'd0);
        check("rst_emit_cnt", 32'(EMIT_CNT), 32'd0);
        check("rst_ill_cnt", 32'(ILL_CNT), 32'd0);
        check("rst_in_ready", 32'(IN_READY), 32'd1);
        RESET_N = 1'b1;

        // Backpressure: second request must wait while the first word is held.
        OUT_READY = 1'b0;
        send(va);
        drive(vb);
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            check("stall_in_ready", 32'(IN_READY), 32'd0);
            check("stall_out_valid", 32'(OUT_VALID), 32'd1);
            check("stall_out_instr", OUT_INSTR, 32'h00221821);
            check("stall_out_pc", OUT_PC, BASE);
            check("stall_emit_cnt", 32'(EMIT_CNT), 32'd0);
        end
        @(posedge CLK); #1;
        OUT_READY = 1'b1;
        send(vb);
        drain();
        check("stall_emit_after", 32'(EMIT_CNT), 32'(m_emit));
        check("stall_emit_two", 32'(m_emit), 32'd2);

        // Reset with a held word: it is dropped and PC/counters restart.
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
        send(vc);
        @(posedge CLK); #1;
        check("pend_out_valid", 32'(OUT_VALID), 32'd1);
        RESET_N = 1'b0;
        sb.delete();
        exp_pc = BASE;
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        check("rst2_out_valid", 32'(OUT_VALID), 32'd0);
        check("rst2_out_pc", OUT_PC, 32'd0);
        check("rst2_emit_cnt", 32'(EMIT_CNT), 32'd0);
        check("rst2_ill_cnt", 32'(ILL_CNT), 32'd0);
        OUT_READY = 1'b1;

        stalls = 0;
        for (int i = 0; i < NVEC; i++) begin
            send(tbl[i]);
        end
        check("no_bubble_stalls", 32'(stalls), 32'd0);
        drain();
        check("emit_cnt_sat", 32'(EMIT_CNT), 32'(m_emit));
        check("ill_cnt", 32'(ILL_CNT), 32'(m_ill));
        check("emit_model_saturated", 32'(m_emit), 32'(CMAX));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
